// File: rtl/fir_coeff_seq.sv
// Coefficient-bank sequencer: decodes toggle-handshaked software commands into
// coefficient RAM writes and frame-aligned bank swaps. FIR_COEFF_CHKSUM_EN adds a write checksum.
module fir_coeff_seq #(
  parameter int N_TAPS = 256,
  parameter int ADDR_W = 8,
  parameter int COEF_W = 18
) (
  input  logic              user_clk,
  input  logic              user_rst,
  input  logic [31:0]       cmd_word,
  input  logic              frame_sync,
  output logic [ADDR_W:0]   coef_addr,
  output logic [COEF_W-1:0] coef_data,
  output logic              coef_we,
  output logic              bank_sel,
  output logic              swap_pulse,
  output logic              busy,
  output logic [7:0]        err_cnt,
  output logic [31:0]       status_word
);

  typedef enum logic [1:0] {
    ST_IDLE        = 2'b00,
    ST_WRITE       = 2'b01,
    ST_CLEAR       = 2'b10,
    ST_COMMIT_WAIT = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_WRITE  = 2'b01,
    OP_COMMIT = 2'b10,
    OP_CLEAR  = 2'b11
  } opcode_e;

  localparam logic [11:0]       TAP_LIMIT = 12'(N_TAPS);
  localparam logic [ADDR_W-1:0] TAP_LAST  = ADDR_W'(N_TAPS - 1);

  state_e              state_q, state_d;
  logic                toggle_q;
  logic                first_q;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [COEF_W-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]   tap_q, tap_d;
  logic                bank_sel_q, bank_sel_d;
  logic                swap_q, swap_d;
  logic [7:0]          err_q, err_d;

  logic                cmd_issue;
  opcode_e             cmd_op;
  logic [10:0]         cmd_tap;
  logic [COEF_W-1:0]   cmd_coef;
  logic                addr_ok;
  logic                cmd_reject;
  logic                clear_start;

  // A command is a flip of bit 31; the cycle right after reset never issues.
  assign cmd_issue = (cmd_word[31] != toggle_q) && !first_q;
  assign cmd_op    = opcode_e'(cmd_word[30:29]);
  assign cmd_tap   = cmd_word[28:18];
  assign cmd_coef  = COEF_W'($signed(cmd_word[17:0]));
  assign addr_ok   = {1'b0, cmd_tap} < TAP_LIMIT;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge user_clk) begin
    toggle_q <= cmd_word[31];
    first_q  <= user_rst;
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_issue) begin
          case (cmd_op)
            OP_WRITE:  if (addr_ok) state_d = ST_WRITE;
            OP_CLEAR:  state_d = ST_CLEAR;
            OP_COMMIT: state_d = ST_COMMIT_WAIT;
            default:   state_d = ST_IDLE;
          endcase
        end
      end
      ST_WRITE:       state_d = ST_IDLE;
      ST_CLEAR:       if (tap_q == TAP_LAST) state_d = ST_IDLE;
      ST_COMMIT_WAIT: if (frame_sync) state_d = ST_IDLE;
    endcase
  end

  assign clear_start = (state_q == ST_IDLE) && (state_d == ST_CLEAR);

  // NOP is harmless anywhere; any other command outside IDLE, or an
  // out-of-range WRITE, counts as a rejection.
  assign cmd_reject = cmd_issue && (cmd_op != OP_NOP) &&
                      ((state_q != ST_IDLE) || ((cmd_op == OP_WRITE) && !addr_ok));

  always_comb begin
    addr_d     = addr_q;
    data_d     = data_q;
    tap_d      = tap_q;
    swap_d     = (state_q == ST_COMMIT_WAIT) && frame_sync;
    bank_sel_d = bank_sel_q ^ swap_d;
    err_d      = err_q;
    if ((state_q == ST_IDLE) && (state_d == ST_WRITE)) begin
      addr_d = cmd_tap[ADDR_W-1:0];
      data_d = cmd_coef;
    end
    if (clear_start) begin
      tap_d = '0;
    end else if ((state_q == ST_CLEAR) && (tap_q != TAP_LAST)) begin
      tap_d = tap_q + ADDR_W'(1);
    end
    if (cmd_reject && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      addr_q     <= '0;
      data_q     <= '0;
      tap_q      <= '0;
      bank_sel_q <= 1'b0;
      swap_q     <= 1'b0;
      err_q      <= 8'd0;
    end else begin
      addr_q     <= addr_d;
      data_q     <= data_d;
      tap_q      <= tap_d;
      bank_sel_q <= bank_sel_d;
      swap_q     <= swap_d;
      err_q      <= err_d;
    end
  end

`ifdef FIR_COEFF_CHKSUM_EN
  logic [15:0] chk_q, chk_d;

  always_comb begin
    chk_d = chk_q;
    if (clear_start) begin
      chk_d = 16'd0;
    end else if (coef_we) begin
      chk_d = chk_q + 16'(coef_data);
    end
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      chk_q <= 16'd0;
    end else begin
      chk_q <= chk_d;
    end
  end
`endif

  // Writes always target the shadow bank; outputs are masked to zero when idle.
  always_comb begin
    busy       = (state_q != ST_IDLE);
    coef_we    = 1'b0;
    coef_addr  = '0;
    coef_data  = '0;
    bank_sel   = bank_sel_q;
    swap_pulse = swap_q;
    err_cnt    = err_q;
    unique case (state_q)
      ST_WRITE: begin
        coef_we   = 1'b1;
        coef_addr = {~bank_sel_q, addr_q};
        coef_data = data_q;
      end
      ST_CLEAR: begin
        coef_we   = 1'b1;
        coef_addr = {~bank_sel_q, tap_q};
      end
      default: ;
    endcase
`ifdef FIR_COEFF_CHKSUM_EN
    status_word = {busy, state_q, bank_sel_q, chk_q, 4'b0000, err_q};
`else
    status_word = {busy, state_q, bank_sel_q, 20'd0, err_q};
`endif
  end

endmodule

// File: tb/tb_fir_coeff_seq.sv
// Directed self-checking bench for fir_coeff_seq (default parameters).
module tb_fir_coeff_seq;

  localparam int N_TAPS = 256;
  localparam int ADDR_W = 8;
  localparam int COEF_W = 18;

  logic              user_clk = 1'b0;
  logic              user_rst = 1'b1;
  logic [31:0]       cmd_word = 32'd0;
  logic              frame_sync = 1'b0;
  logic [ADDR_W:0]   coef_addr;
  logic [COEF_W-1:0] coef_data;
  logic              coef_we;
  logic              bank_sel;
  logic              swap_pulse;
  logic              busy;
  logic [7:0]        err_cnt;
  logic [31:0]       status_word;

  int checks = 0;
  int failures = 0;

  always #5 user_clk = ~user_clk;

  fir_coeff_seq #(.N_TAPS(N_TAPS), .ADDR_W(ADDR_W), .COEF_W(COEF_W)) dut (
    .user_clk(user_clk), .user_rst(user_rst), .cmd_word(cmd_word), .frame_sync(frame_sync),
    .coef_addr(coef_addr), .coef_data(coef_data), .coef_we(coef_we), .bank_sel(bank_sel),
    .swap_pulse(swap_pulse), .busy(busy), .err_cnt(err_cnt), .status_word(status_word)
  );

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [10:0] tap, input logic [17:0] coef);
    cmd_word = {~cmd_word[31], op, tap, coef};
  endtask

  // Issues CLEAR and follows it to IDLE, optionally injecting a WRITE after inject_at cycles.
  task automatic run_clear(input int inject_at, input logic bank_hi,
                           output int n_we, output int n_bad, output logic done);
    logic [ADDR_W:0] exp_addr;
    n_we = 0; n_bad = 0; done = 1'b0;
    issue(2'b11, 11'd0, 18'd0);
    for (int cyc = 1; cyc <= 400; cyc++) begin
      tick();
      if (!busy) begin
        done = 1'b1;
        break;
      end
      exp_addr = {bank_hi, ADDR_W'(n_we)};
      if (!coef_we || coef_addr !== exp_addr || coef_data !== '0) n_bad++;
      if (coef_we) n_we++;
      if (cyc == inject_at) issue(2'b01, 11'd7, 18'h12345);
    end
  endtask

  task automatic test_reset();
    user_rst = 1'b1;
    frame_sync = 1'b1;
    cmd_word = 32'hFFFF_FFFF;
    repeat (3) tick();
    frame_sync = 1'b0;
    checks++; if (coef_we !== 1'b0 || coef_addr !== '0 || coef_data !== '0) begin failures++; $display("FAIL reset_coef: we=%0b addr=%h data=%h expected 0/0/0", coef_we, coef_addr, coef_data); end
    checks++; if (bank_sel !== 1'b0 || swap_pulse !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_ctrl: bank=%0b swap=%0b busy=%0b expected 0/0/0", bank_sel, swap_pulse, busy); end
    checks++; if (err_cnt !== 8'd0 || status_word !== 32'd0) begin failures++; $display("FAIL reset_status: err=%0d status=%h expected 0/00000000", err_cnt, status_word); end
    user_rst = 1'b0;
    issue(2'b01, 11'd1, 18'd9);
    tick();
    tick();
    checks++; if (busy !== 1'b0 || coef_we !== 1'b0) begin failures++; $display("FAIL reset_first_cycle: busy=%0b we=%0b expected 0/0", busy, coef_we); end
  endtask

  task automatic test_write();
    int busy_cycles;
    issue(2'b01, 11'd5, 18'h1FFFF);
    checks++; if (busy !== 1'b0 || coef_we !== 1'b0) begin failures++; $display("FAIL write_issue_cycle: busy=%0b we=%0b expected 0/0", busy, coef_we); end
    tick();
    checks++; if (coef_we !== 1'b1 || coef_addr !== 9'h105 || coef_data !== 18'h1FFFF) begin failures++; $display("FAIL write_addr5: we=%0b addr=%h data=%h expected 1/105/1ffff", coef_we, coef_addr, coef_data); end
    busy_cycles = busy ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (busy) busy_cycles++;
    end
    checks++; if (busy_cycles !== 1 || coef_we !== 1'b0) begin failures++; $display("FAIL write_busy_len: busy_cycles=%0d we=%0b expected 1/0", busy_cycles, coef_we); end
    issue(2'b01, 11'd255, 18'h00ABC);
    tick();
    checks++; if (coef_we !== 1'b1 || coef_addr !== 9'h1FF || coef_data !== 18'h00ABC) begin failures++; $display("FAIL write_addr255: we=%0b addr=%h data=%h expected 1/1ff/00abc", coef_we, coef_addr, coef_data); end
    tick();
  endtask

  task automatic test_clear();
    int n_we, n_bad;
    logic done;
    run_clear(-1, 1'b1, n_we, n_bad, done);
    checks++; if (n_we !== 256 || n_bad !== 0) begin failures++; $display("FAIL clear_writes: writes=%0d bad=%0d expected 256/0", n_we, n_bad); end
    checks++; if (done !== 1'b1 || coef_we !== 1'b0 || status_word[30:29] !== 2'b00) begin failures++; $display("FAIL clear_idle: done=%0b we=%0b state=%0d expected 1/0/0", done, coef_we, status_word[30:29]); end
  endtask

  task automatic test_write_during_clear();
    int n_we, n_bad;
    logic done;
    run_clear(10, 1'b1, n_we, n_bad, done);
    checks++; if (n_we !== 256 || n_bad !== 0 || done !== 1'b1) begin failures++; $display("FAIL clear_inject_writes: writes=%0d bad=%0d done=%0b expected 256/0/1", n_we, n_bad, done); end
    checks++; if (err_cnt !== 8'd1) begin failures++; $display("FAIL clear_inject_err: err=%0d expected 1", err_cnt); end
  endtask

  task automatic test_commit();
    int swaps;
    issue(2'b10, 11'd0, 18'd0);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    checks++; if (status_word[31:28] !== 4'hE || swap_pulse !== 1'b0 || coef_we !== 1'b0) begin failures++; $display("FAIL commit_wait: status_hi=%h swap=%0b we=%0b expected e/0/0", status_word[31:28], swap_pulse, coef_we); end
    swaps = 0;
    for (int i = 0; i < 19; i++) begin
      tick();
      if (swap_pulse || bank_sel || coef_we) swaps++;
    end
    checks++; if (swaps !== 0 || busy !== 1'b1) begin failures++; $display("FAIL commit_hold: early_events=%0d busy=%0b expected 0/1", swaps, busy); end
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    checks++; if (bank_sel !== 1'b1 || swap_pulse !== 1'b1 || busy !== 1'b0 || status_word[28] !== 1'b1) begin failures++; $display("FAIL commit_swap: bank=%0b swap=%0b busy=%0b st28=%0b expected 1/1/0/1", bank_sel, swap_pulse, busy, status_word[28]); end
    tick();
    checks++; if (bank_sel !== 1'b1 || swap_pulse !== 1'b0) begin failures++; $display("FAIL commit_after: bank=%0b swap=%0b expected 1/0", bank_sel, swap_pulse); end
  endtask

  task automatic test_back_to_back();
    issue(2'b01, 11'd20, 18'h2ABCD);
    tick();
    checks++; if (coef_we !== 1'b1 || coef_addr !== 9'h014 || coef_data !== 18'h2ABCD) begin failures++; $display("FAIL b2b_first: we=%0b addr=%h data=%h expected 1/014/2abcd", coef_we, coef_addr, coef_data); end
    issue(2'b01, 11'd21, 18'd6);
    tick();
    checks++; if (coef_we !== 1'b0 || busy !== 1'b0 || err_cnt !== 8'd2) begin failures++; $display("FAIL b2b_drop: we=%0b busy=%0b err=%0d expected 0/0/2", coef_we, busy, err_cnt); end
    tick();
  endtask

  task automatic test_checksum();
    int n_we, n_bad;
    logic done;
    run_clear(-1, 1'b0, n_we, n_bad, done);
    checks++; if (n_we !== 256 || n_bad !== 0 || done !== 1'b1) begin failures++; $display("FAIL clear_bank0: writes=%0d bad=%0d done=%0b expected 256/0/1", n_we, n_bad, done); end
    issue(2'b01, 11'd1, 18'd3);
    tick(); tick();
    issue(2'b01, 11'd2, 18'd4);
    tick(); tick();
`ifdef FIR_COEFF_CHKSUM_EN
    checks++; if (status_word[27:12] !== 16'd7 || status_word[11:8] !== 4'd0) begin failures++; $display("FAIL checksum: sum=%0d low=%0d expected 7/0", status_word[27:12], status_word[11:8]); end
`else
    checks++; if (status_word[27:8] !== 20'd0) begin failures++; $display("FAIL status_mid_zero: got %h expected 00000", status_word[27:8]); end
`endif
  endtask

  task automatic test_bad_addr();
    int writes;
    issue(2'b01, 11'd256, 18'd1);
    tick();
    checks++; if (coef_we !== 1'b0 || busy !== 1'b0 || err_cnt !== 8'd3) begin failures++; $display("FAIL bad_addr256: we=%0b busy=%0b err=%0d expected 0/0/3", coef_we, busy, err_cnt); end
    writes = 0;
    for (int i = 0; i < 260; i++) begin
      issue(2'b01, 11'd300, 18'd1);
      tick();
      if (coef_we || busy) writes++;
    end
    checks++; if (writes !== 0) begin failures++; $display("FAIL bad_addr300_we: write_cycles=%0d expected 0", writes); end
    checks++; if (err_cnt !== 8'd255 || status_word[7:0] !== 8'd255) begin failures++; $display("FAIL err_saturate: err=%0d status=%0d expected 255/255", err_cnt, status_word[7:0]); end
  endtask

  task automatic test_reset_abort();
    int events;
    issue(2'b11, 11'd0, 18'd0);
    repeat (50) tick();
    user_rst = 1'b1;
    tick();
    checks++; if (coef_we !== 1'b0 || bank_sel !== 1'b0 || err_cnt !== 8'd0 || busy !== 1'b0) begin failures++; $display("FAIL rst_mid_clear: we=%0b bank=%0b err=%0d busy=%0b expected 0/0/0/0", coef_we, bank_sel, err_cnt, busy); end
    user_rst = 1'b0;
    events = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (coef_we || busy) events++;
    end
    checks++; if (events !== 0) begin failures++; $display("FAIL rst_clear_resume: events=%0d expected 0", events); end
    issue(2'b10, 11'd0, 18'd0);
    repeat (3) tick();
    user_rst = 1'b1;
    frame_sync = 1'b1;
    tick();
    user_rst = 1'b0;
    tick();
    frame_sync = 1'b0;
    events = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (swap_pulse || bank_sel || busy) events++;
    end
    checks++; if (events !== 0 || bank_sel !== 1'b0) begin failures++; $display("FAIL rst_mid_commit: events=%0d bank=%0b expected 0/0", events, bank_sel); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_clear();
    test_write_during_clear();
    test_commit();
    test_back_to_back();
    test_checksum();
    test_bad_addr();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
